gpio_rx_debounce: RTL and testbench
===================================

# gpio_rx_debounce

Input-side companion to the blink/display output path: samples one raw, asynchronous board input (push-button or GPIO0 input pin), synchronizes and debounces it, and produces a clean level, single-cycle press/release pulses and a press count. It sits between the board pin and the state machines in the top level, which use it to start, stop or step the blink pattern.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; documentation and derived-constant use only.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles (20 ms at 50 MHz) required to accept a change; legal range ≥ 2.
- ACTIVE_LOW, 1, 1: raw pin reads 0 when pressed (DE0 buttons); 0: pin reads 1 when pressed.
- LONG_CYCLES, 50_000_000, hold time in cycles for a long press (1 s); used only when GPIO_RX_LONGPRESS_EN is defined.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- GPIO_IN  input  1  raw asynchronous pin.
- level  output  1  debounced state, 1 = pressed.
- rise  output  1  one-cycle pulse on debounced press.
- fall  output  1  one-cycle pulse on debounced release.
- long_press  output  1  one-cycle pulse when a press has been held LONG_CYCLES.
- press_cnt  output  8  number of accepted presses, modulo 256.

## Operation
- Polarity: raw pin inverted when ACTIVE_LOW=1, so internal signal `pressed_raw` is active-high.
- Synchronizer: two flip-flops; after reset both hold 0 (not pressed).
- Debounce FSM, four states:
  - IDLE_LO: level=0; synced=1 → CHK_HI, counter=1.
  - CHK_HI: synced=1 → counter++; counter reaches DEBOUNCE_CYCLES → IDLE_HI, level←1, rise pulse. synced=0 → IDLE_LO, counter←0, no pulse.
  - IDLE_HI: level=1; synced=0 → CHK_LO, counter=1.
  - CHK_LO: mirror of CHK_HI; completion → IDLE_LO, level←0, fall pulse.
- Counter width $clog2(DEBOUNCE_CYCLES+1); never wraps, cleared on every return to IDLE.
- press_cnt increments on the same edge as rise; 255 → 0 wraps silently.
- rise and fall are never asserted together; each lasts exactly one cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no output change.

## Timing
- Reset values: level=0, rise=0, fall=0, long_press=0, press_cnt=0, FSM=IDLE_LO, all counters 0, synchronizer 0.
- Latency: pin changes and stays stable → level and pulse update on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new value (2 synchronizer + DEBOUNCE_CYCLES filter).
- Pin already pressed when RST deasserts: treated as a fresh press; rise fires after the same latency.
- RST asserted mid-check or mid-hold: pending transition and long-press hold discarded; no pulse emitted; outputs at reset values on the next edge.
- RST has priority over every other event in the same cycle.

## Configuration
- GPIO_RX_LONGPRESS_EN defined: hold counter (width $clog2(LONG_CYCLES+1)) starts at 0 on rise, increments each cycle in IDLE_HI/CHK_LO, saturates; long_press pulses once on the edge it reaches LONG_CYCLES; no repeat until a fall and a new rise. A release completing on that same edge suppresses the pulse.
- Not defined: hold counter absent, long_press tied to 0, LONG_CYCLES ignored.

## Structure
- Package gpio_rx_pkg: FSM state enum (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO) and the default cycle-count constants.
- One sub-module: sync2 (two-flop synchronizer, synchronous active-high reset, parameterized reset value), reusable for other board inputs.

## Test plan
- Params DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1, macro defined for all cases.
- Reset, pin held 1 → level=0, no pulses for 20 cycles, press_cnt=0.
- Pin 1→0 held → rise high exactly on edge 6 after first sampling edge, level=1, press_cnt=1; release → fall after 6 edges.
- Pin low for 3 cycles then high (bounce) → no rise, level stays 0, FSM back to IDLE_LO.
- Hold press 20 cycles past rise → single long_press pulse 10 cycles after rise; none repeated.
- RST asserted in CHK_HI at counter=2 → no rise, all outputs 0 next edge; 256 clean presses → press_cnt wraps to 0.

Source files
------------

// File: rtl/gpio_rx_pkg.sv
// gpio_rx_pkg: shared types and default constants for the board-input
// receive path (synchronizer + debounce + press bookkeeping).
package gpio_rx_pkg;

  // Debounce FSM states: two stable states and one check state per direction.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } db_state_e;

  // Default cycle counts for a 50 MHz board clock.
  localparam int unsigned DEF_CLK_HZ          = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;  // 1 s
  localparam bit          DEF_ACTIVE_LOW      = 1'b1;

  // Map the raw pin level to an active-high "pressed" indication.
  function automatic logic to_pressed(input logic pin, input bit active_low);
    return active_low ? ~pin : pin;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input bit.
// Synchronous active-high reset loads RST_VAL into both stages.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_rx_debounce.sv
// gpio_rx_debounce: synchronizes and debounces one raw board input and
// produces a clean pressed level, one-cycle press/release pulses and an
// 8-bit modulo press count.
// Optional feature: define GPIO_RX_LONGPRESS_EN to add a hold counter that
// pulses long_press once per press held for LONG_CYCLES; otherwise
// long_press is tied low and LONG_CYCLES is ignored.
module gpio_rx_debounce
  import gpio_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GPIO_IN,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       long_press,
  output logic [7:0] press_cnt
);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("gpio_rx_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (CLK_HZ == 0) begin : g_bad_clk
    $error("gpio_rx_debounce: CLK_HZ must be non-zero");
  end
  if (LONG_CYCLES == 0) begin : g_bad_long
    $error("gpio_rx_debounce: LONG_CYCLES must be non-zero");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic pressed_raw;
  logic synced;

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [7:0]    press_cnt_q, press_cnt_d;

  assign pressed_raw = to_pressed(GPIO_IN, ACTIVE_LOW);

  sync2 #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (pressed_raw),
    .q_o   (synced)
  );

  // Debounce next-state: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synced samples of the new value; the counter's final
  // increment and the transition share one edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    unique case (state_q)
      IDLE_LO: begin
        level_d = 1'b0;
        cnt_d   = '0;
        if (synced) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!synced) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE_HI;
          cnt_d       = '0;
          level_d     = 1'b1;
          rise_d      = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        level_d = 1'b1;
        cnt_d   = '0;
        if (!synced) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (synced) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Debounce state, counter and registered outputs; reset wins over all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE_LO;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign press_cnt = press_cnt_q;

`ifdef GPIO_RX_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold counter: restarts on each accepted press, counts while the
  // debounced level is high, saturates so the pulse cannot repeat; a
  // release accepted on the threshold edge suppresses the pulse.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (rise_d) begin
      hold_d = '0;
    end else if (state_q == IDLE_HI || state_q == CHK_LO) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_ONE;
      end
      if (hold_q == HOLD_LAST && !fall_d) begin
        long_d = 1'b1;
      end
    end else begin
      hold_d = '0;
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_rx_debounce.sv
// Bench for gpio_rx_debounce: directed steps plus randomized pin activity,
// compared every cycle against a sliding-window reference model.
module tb_gpio_rx_debounce;

  localparam int DB = 4;
  localparam int LC = 10;
  localparam bit AL = 1'b1;
`ifdef GPIO_RX_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       GPIO_IN;
  logic       level;
  logic       rise;
  logic       fall;
  logic       long_press;
  logic [7:0] press_cnt;

  int checks   = 0;
  int failures = 0;

  gpio_rx_debounce #(
    .CLK_HZ          (50_000_000),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (AL),
    .LONG_CYCLES     (LC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .GPIO_IN    (GPIO_IN),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press),
    .press_cnt  (press_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model state: 2-cycle sync delay, window of the last DB
  // samples seen by the filter, expected outputs, cycles since last press.
  bit         m_dly0, m_dly1;
  bit         m_win[$];
  bit         m_level, m_rise, m_fall, m_lp;
  logic [7:0] m_cnt = 8'd0;
  int         m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level flips once the last DB filtered samples all disagree with it.
  task automatic model_edge(input logic rst_v, input logic pin_v);
    bit pr, seen, prev, same, tmp;
    pr     = AL ? ~pin_v : pin_v;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_lp   = 1'b0;
    if (rst_v) begin
      m_dly0 = 1'b0;
      m_dly1 = 1'b0;
      m_win.delete();
      m_level = 1'b0;
      m_cnt   = 8'd0;
      m_since = 0;
      return;
    end
    seen   = m_dly0;
    m_dly0 = m_dly1;
    m_dly1 = pr;
    prev   = m_level;
    m_win.push_back(seen);
    if (m_win.size() > DB) tmp = m_win.pop_front();
    if (m_win.size() == DB) begin
      same = 1'b1;
      foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 1'b0;
      if (same && m_win[0] != m_level) begin
        m_level = m_win[0];
        if (m_level) begin
          m_rise  = 1'b1;
          m_cnt   = m_cnt + 8'd1;
          m_since = 0;
        end else begin
          m_fall = 1'b1;
        end
      end
    end
    if (prev) begin
      m_since++;
      if (m_since == LC && !m_fall) m_lp = 1'b1;
    end
  endtask

  task automatic tick();
    bit exp_lp;
    @(posedge CLK);
    model_edge(RST, GPIO_IN);
    #1;
    exp_lp = LP_EN ? m_lp : 1'b0;
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("long_press", long_press, exp_lp);
    chk("press_cnt", press_cnt, m_cnt);
    chk("rise_fall_excl", rise & fall, 0);
  endtask

  task automatic run_find(input int n, output int rise_e, output int fall_e,
                          output int long_e, output int n_long);
    rise_e = 0; fall_e = 0; long_e = 0; n_long = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (rise && rise_e == 0) rise_e = i;
      if (fall && fall_e == 0) fall_e = i;
      if (long_press) begin
        n_long++;
        if (long_e == 0) long_e = i;
      end
    end
  endtask

  initial begin
    int re, fe, le, nl, len;
    RST     = 1'b1;
    GPIO_IN = 1'b1;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_pulses", {rise, fall, long_press}, 0);

    // Released pin after reset: nothing happens.
    RST = 1'b0;
    run_find(20, re, fe, le, nl);
    chk("idle_rise", re, 0);
    chk("idle_fall", fe, 0);
    chk("idle_level", level, 0);

    // Press and hold: rise on edge 6, long press 10 edges later, once.
    GPIO_IN = 1'b0;
    run_find(30, re, fe, le, nl);
    chk("press_rise_edge", re, 6);
    chk("press_level", level, 1);
    chk("press_cnt_1", press_cnt, 1);
    chk("long_edge", le, LP_EN ? 16 : 0);
    chk("long_count", nl, LP_EN ? 1 : 0);

    // Release.
    GPIO_IN = 1'b1;
    run_find(14, re, fe, le, nl);
    chk("release_fall_edge", fe, 6);
    chk("release_level", level, 0);
    chk("release_rise", re, 0);

    // Bounce of 3 cycles is rejected.
    GPIO_IN = 1'b0;
    repeat (3) tick();
    GPIO_IN = 1'b1;
    run_find(12, re, fe, le, nl);
    chk("bounce_rise", re, 0);
    chk("bounce_level", level, 0);

    // A clean press afterwards sees the full, unshortened latency.
    GPIO_IN = 1'b0;
    run_find(12, re, fe, le, nl);
    chk("post_bounce_rise_edge", re, 6);
    chk("press_cnt_2", press_cnt, 2);

    // Reset mid-hold discards the pending long press.
    repeat (2) tick();
    RST     = 1'b1;
    GPIO_IN = 1'b1;
    tick();
    chk("rst_hold_level", level, 0);
    chk("rst_hold_cnt", press_cnt, 0);
    RST = 1'b0;
    run_find(20, re, fe, le, nl);
    chk("rst_hold_long", nl, 0);
    chk("rst_hold_rise", re, 0);

    // Reset in CHK_HI at counter 2; pin stays pressed through reset.
    GPIO_IN = 1'b0;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    chk("rst_chk_level", level, 0);
    chk("rst_chk_rise", rise, 0);
    RST = 1'b0;
    run_find(12, re, fe, le, nl);
    chk("rst_fresh_rise_edge", re, 6);
    chk("rst_fresh_cnt", press_cnt, 1);
    GPIO_IN = 1'b1;
    repeat (10) tick();

    // Randomized bursts with occasional reset.
    for (int b = 0; b < 80; b++) begin
      GPIO_IN = 1'($urandom_range(0, 1));
      len     = int'($urandom_range(1, 9));
      RST     = ($urandom_range(0, 19) == 0);
      tick();
      RST = 1'b0;
      repeat (len - 1) tick();
    end
    GPIO_IN = 1'b1;
    repeat (20) tick();

    // 256 clean presses wrap the counter back to 0.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      GPIO_IN = 1'b0;
      repeat (7) tick();
      GPIO_IN = 1'b1;
      repeat (7) tick();
      if (k == 255) chk("wrap_255", press_cnt, 255);
    end
    chk("wrap_0", press_cnt, 0);
    chk("wrap_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
